// File: rtl/fec_cc_tb_encoder.sv
// Tail-biting K=7 convolutional encoder (G1=171o -> X, G2=133o -> Y) with a serial, backpressured
// output. Define FEC_PUNCTURE_EN to honour rate_sel (2/3, 3/4); otherwise the output is rate 1/2.
module fec_cc_tb_encoder #(
  parameter int unsigned BLOCK_LEN = 96,
  parameter int unsigned CNT_W     = $clog2(2 * BLOCK_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       fec_in,
  input  logic [1:0] rate_sel,
  output logic       fec_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       first_out,
  output logic       last_out
);

  typedef enum logic [1:0] {StLoad, StPrime, StEncode} state_e;

  state_e               state_q, state_d;
  logic [BLOCK_LEN-1:0] data_q, data_d;
  logic [CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic                 y_sel_q, y_sel_d;
  logic [5:0]           enc_q, enc_d;
  logic                 fec_out_q, fec_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;

  logic in_xfer, cur_bit, x_bit, y_bit, keep_y, keep_x_nxt, bit_done, load_out;

  assign ready_out = (state_q == StLoad);
  assign in_xfer   = valid_in && ready_out;

  // data_q is rotated so the data bit being encoded always sits at data_q[0]
  assign cur_bit = data_q[0];
  assign x_bit   = cur_bit ^ enc_q[0] ^ enc_q[1] ^ enc_q[2] ^ enc_q[5];
  assign y_bit   = cur_bit ^ enc_q[1] ^ enc_q[2] ^ enc_q[4] ^ enc_q[5];

`ifdef FEC_PUNCTURE_EN
  logic [1:0] rate_q, rate_d;
  logic [1:0] ph_q, ph_d;
  logic [1:0] ph_nxt;

  always_comb begin
    keep_y     = 1'b1;
    ph_nxt     = 2'd0;
    keep_x_nxt = 1'b1;
    unique case (rate_q)
      2'b01: begin
        ph_nxt     = (ph_q == 2'd1) ? 2'd0 : ph_q + 2'd1;
        keep_x_nxt = (ph_nxt == 2'd0);
      end
      2'b10: begin
        keep_y     = (ph_q != 2'd2);
        ph_nxt     = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        keep_x_nxt = (ph_nxt != 2'd1);
      end
      default: begin
        ph_nxt     = 2'd0;
        keep_x_nxt = 1'b1;
      end
    endcase
  end
`else
  logic unused_rate_sel;
  assign unused_rate_sel = ^rate_sel;
  assign keep_y          = 1'b1;
  assign keep_x_nxt      = 1'b1;
`endif

  // Current position is the last surviving bit of this data bit: shift the encoder afterwards
  assign bit_done = y_sel_q || !keep_y;
  assign load_out = (!valid_out_q || ready_in) && !(valid_out_q && last_q);

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    in_cnt_d    = in_cnt_q;
    idx_d       = idx_q;
    y_sel_d     = y_sel_q;
    enc_d       = enc_q;
    fec_out_d   = fec_out_q;
    valid_out_d = valid_out_q;
    first_d     = first_q;
    last_d      = last_q;
`ifdef FEC_PUNCTURE_EN
    rate_d      = rate_q;
    ph_d        = ph_q;
`endif
    unique case (state_q)
      StLoad: begin
        if (in_xfer) begin
          data_d   = {fec_in, data_q[BLOCK_LEN-1:1]};
          in_cnt_d = in_cnt_q + CNT_W'(1);
`ifdef FEC_PUNCTURE_EN
          if (in_cnt_q == '0) rate_d = rate_sel;
`endif
          if (in_cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
            in_cnt_d = '0;
            state_d  = StPrime;
          end
        end
      end
      StPrime: begin
        for (int j = 0; j < 6; j++) enc_d[j] = data_q[BLOCK_LEN-1-j];
        idx_d   = '0;
        y_sel_d = 1'b0;
`ifdef FEC_PUNCTURE_EN
        ph_d    = 2'd0;
`endif
        state_d = StEncode;
      end
      StEncode: begin
        if (valid_out_q && last_q && ready_in) begin
          valid_out_d = 1'b0;
          fec_out_d   = 1'b0;
          first_d     = 1'b0;
          last_d      = 1'b0;
          state_d     = StLoad;
        end else if (load_out) begin
          fec_out_d   = y_sel_q ? y_bit : x_bit;
          valid_out_d = 1'b1;
          first_d     = (idx_q == '0) && !y_sel_q;
          last_d      = bit_done && (idx_q == CNT_W'(BLOCK_LEN - 1));
          if (bit_done) begin
            enc_d   = {enc_q[4:0], cur_bit};
            data_d  = {data_q[0], data_q[BLOCK_LEN-1:1]};
            idx_d   = idx_q + CNT_W'(1);
            y_sel_d = !keep_x_nxt;
`ifdef FEC_PUNCTURE_EN
            ph_d    = ph_nxt;
`endif
          end else begin
            y_sel_d = 1'b1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StLoad;
      data_q      <= '0;
      in_cnt_q    <= '0;
      idx_q       <= '0;
      y_sel_q     <= 1'b0;
      enc_q       <= '0;
      fec_out_q   <= 1'b0;
      valid_out_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
`ifdef FEC_PUNCTURE_EN
      rate_q      <= 2'b00;
      ph_q        <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      in_cnt_q    <= in_cnt_d;
      idx_q       <= idx_d;
      y_sel_q     <= y_sel_d;
      enc_q       <= enc_d;
      fec_out_q   <= fec_out_d;
      valid_out_q <= valid_out_d;
      first_q     <= first_d;
      last_q      <= last_d;
`ifdef FEC_PUNCTURE_EN
      rate_q      <= rate_d;
      ph_q        <= ph_d;
`endif
    end
  end

  assign fec_out   = fec_out_q;
  assign valid_out = valid_out_q;
  assign first_out = first_q;
  assign last_out  = last_q;

endmodule

// File: tb/tb_fec_cc_tb_encoder.sv
// Directed bench for fec_cc_tb_encoder: expected output bits are queued when a block is sent and
// popped by a monitor on every output transfer.
module tb_fec_cc_tb_encoder;

  localparam int L = 96;
  localparam logic [95:0]  IN_VEC  = 96'h558AC4A53A1724E163AC2BF9;
  localparam logic [191:0] OUT_VEC = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic       fec_in = 1'b0;
  logic       ready_in = 1'b1;
  logic [1:0] rate_sel = 2'b00;
  logic       ready_out, fec_out, valid_out, first_out, last_out;

  int   checks = 0;
  int   errors = 0;
  int   out_n = 0;
  exp_t exp_q[$];
  logic stall_seen = 1'b0;
  logic [2:0] held = 3'b000;

  fec_cc_tb_encoder #(.BLOCK_LEN(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .fec_in   (fec_in),
    .rate_sel (rate_sel),
    .fec_out  (fec_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .first_out(first_out),
    .last_out (last_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen)
        check("stall_hold", 32'({valid_out, fec_out, first_out, last_out}), 32'({1'b1, held}));
      stall_seen = valid_out && !ready_in;
      held       = {fec_out, first_out, last_out};
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(valid_out), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("out[%0d]", out_n), 32'({fec_out, first_out, last_out}), 32'(e));
        end
        out_n++;
      end
    end
  end

  task automatic push_bits(input logic [191:0] v, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b = v[191-i];
      e.f = (i == 0);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Reference encoder: state bit s_j is data bit (i-j) mod L, taps from the octal generators
  task automatic push_model(input logic [95:0] v, input logic [1:0] r);
    logic [191:0] s;
    logic [6:0]   sr;
    int           n, eff, p, ph;
    logic         kx, ky;
    s = '0;
    n = 0;
`ifdef FEC_PUNCTURE_EN
    eff = int'(r);
`else
    eff = 0;
`endif
    p = (eff == 1) ? 2 : (eff == 2) ? 3 : 1;
    for (int i = 0; i < L; i++) begin
      sr[6] = v[95-i];
      for (int j = 1; j <= 6; j++) sr[6-j] = v[95-((i - j + L) % L)];
      ph = i % p;
      kx = (eff == 1) ? (ph == 0) : (eff == 2) ? (ph != 1) : 1'b1;
      ky = (eff == 2) ? (ph != 2) : 1'b1;
      if (kx) begin s[191-n] = ^(sr & 7'o171); n++; end
      if (ky) begin s[191-n] = ^(sr & 7'o133); n++; end
    end
    push_bits(s, n);
  endtask

  task automatic send_block(input logic [95:0] v, input logic [1:0] r, input bit gaps);
    int guard;
    for (int k = 0; k < L; k++) begin
      if (gaps && (k % 5) == 2) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      fec_in   = v[95-k];
      rate_sel = (k == 0) ? r : ~r;
      guard    = 0;
      @(negedge clk);
      while (!ready_out && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (!ready_out) begin
        check("in_timeout", 32'(ready_out), 32'(1));
        valid_in = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int n, stall;
    bit done;
    n = 0; stall = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      if (bp && n == 50 && stall < 10) begin
        ready_in = 1'b0;
        stall++;
      end else if (bp && n > 50) begin
        ready_in = cyc[0];
      end else begin
        ready_in = 1'b1;
      end
      @(negedge clk);
      if (valid_out && ready_in) begin
        n++;
        done = last_out;
      end
      @(posedge clk); #1;
    end
    ready_in = 1'b1;
    check("drain_done", 32'(done), 32'(1));
    if (done) check("rdy_after_last", 32'({ready_out, valid_out}), 32'(2'b10));
    check("queue_empty", 32'(exp_q.size()), 32'(0));
  endtask

  logic [95:0] rnd;

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({ready_out, valid_out, fec_out, first_out, last_out}), 32'(5'b10000));
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_release", 32'({ready_out, valid_out}), 32'(2'b10));

    // Reference vector, with latency of the first valid_out
    out_n = 0;
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b00, 1'b0);
    check("prime_handshake", 32'({ready_out, valid_out}), 32'(2'b00));
    @(posedge clk); #1;
    check("lat_cycle1", 32'(valid_out), 32'(0));
    @(posedge clk); #1;
    check("lat_cycle2", 32'({valid_out, first_out}), 32'(2'b11));
    drain(1'b0);

    // Five back-to-back blocks, one with input gaps
    for (int b = 0; b < 5; b++) begin
      out_n = 0;
      push_bits(OUT_VEC, 192);
      send_block(IN_VEC, 2'b00, b == 2);
      drain(1'b0);
    end

    // Backpressure at output bit 50
    out_n = 0;
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b00, 1'b0);
    drain(1'b1);

    // Reset pulse mid-stream, then a fresh block
    out_n = 0;
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b00, 1'b0);
    for (int g = 0; g < 1000 && out_n < 50; g++) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_outputs",
          32'({ready_out, valid_out, fec_out, first_out, last_out}), 32'(5'b10000));
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    out_n = 0;
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b00, 1'b0);
    drain(1'b0);

    // All-zero and all-one blocks
    push_bits(192'd0, 192);
    send_block(96'd0, 2'b00, 1'b0);
    drain(1'b0);
    push_bits({192{1'b1}}, 192);
    send_block({96{1'b1}}, 2'b00, 1'b0);
    drain(1'b0);

    // Rate selection: punctured when compiled in, otherwise always rate 1/2
`ifdef FEC_PUNCTURE_EN
    push_model(IN_VEC, 2'b10);
    send_block(IN_VEC, 2'b10, 1'b0);
    drain(1'b0);
    push_model(IN_VEC, 2'b01);
    send_block(IN_VEC, 2'b01, 1'b1);
    drain(1'b1);
`else
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b10, 1'b0);
    drain(1'b0);
`endif

    // Random block with reserved rate; valid_in held high across the last output transfer
    rnd = {$urandom, $urandom, $urandom};
    push_model(rnd, 2'b11);
    send_block(rnd, 2'b11, 1'b1);
    valid_in = 1'b1;
    fec_in   = 1'b1;
    drain(1'b1);
    valid_in = 1'b0;
    push_bits(OUT_VEC, 192);
    send_block(IN_VEC, 2'b00, 1'b0);
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fec_cc_tb_encoder.md
Name: fec_cc_tb_encoder

Overview:
Parametrised tail-biting convolutional encoder for the 802.16 OFDM PHY chain. It sits between the randomizer and the interleaver. It buffers one FEC block of BLOCK_LEN bits, pre-loads the encoder state with the block's last 6 bits, then emits the K=7 encoded stream (G1=171o gives X, G2=133o gives Y) serially with backpressure. It replaces the fixed 96-bit, dual-clock encoder: single clock, any block length, optional puncturing.

Parameters:
BLOCK_LEN, 96, data bits per FEC block; must be ≥6 and, with puncturing compiled in, a multiple of 6.
CNT_W, $clog2(2*BLOCK_LEN+1), width of the internal bit counters.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
valid_in  input  1  fec_in is valid
ready_out  output  1  block can accept a bit (LOAD state)
fec_in  input  1  randomized data bit, first bit of block first
rate_sel  input  2  00: 1/2; 01: 2/3; 10: 3/4; 11: reserved, treated as 1/2
fec_out  output  1  encoded bit
valid_out  output  1  fec_out is valid
ready_in  input  1  downstream accepts fec_out
first_out  output  1  high with the first encoded bit of a block
last_out  output  1  high with the last encoded bit of a block

Behaviour:
- Reset (reset=0, asynchronous): state LOAD, counters 0, encoder state 0, ready_out=1, valid_out=0, fec_out=0, first_out=0, last_out=0. Any partial block is discarded.
- Input transfer occurs on a clk edge with valid_in && ready_out. Bit k (k=0 first) is stored at buf[k]. Gaps in valid_in are allowed.
- rate_sel is sampled on transfer of bit 0. Later changes within the block are ignored.
- LOAD: on transfer of bit BLOCK_LEN-1, go to PRIME and drop ready_out on the same edge.
- PRIME (1 cycle): encoder state ← {buf[BLOCK_LEN-1] … buf[BLOCK_LEN-6]}, most recent bit first. Output index ← 0. Go to ENCODE.
- ENCODE: per data bit i, X = buf[i]^s1^s2^s3^s6 and Y = buf[i]^s2^s3^s5^s6 (s1 = newest state bit).
  - Mother order is X_i then Y_i. The state shifts in buf[i] after the last surviving bit of bit i.
  - fec_out and valid_out are registered. The first valid_out is asserted 2 cycles after the last input transfer.
  - An output transfer occurs on valid_out && ready_in. The next bit is presented on the following edge.
  - While ready_in=0, fec_out, first_out and last_out hold stable and valid_out stays 1.
  - With ready_in held high, the block streams one bit per cycle with no bubbles.
- Output bit counts per block: 1/2 gives 2·BLOCK_LEN; 2/3 gives 3·BLOCK_LEN/2; 3/4 gives 4·BLOCK_LEN/3.
- Flags: first_out is high only on output bit 0. last_out is high only on the final bit.
- After the last_out transfer, the next edge sets valid_out=0, ready_out=1 and the state to LOAD. No input is accepted during PRIME or ENCODE.
- Tail-biting: the final encoder state equals the PRIME state. No flush bits are emitted.
- Mid-block reset: all outputs return to reset values immediately. The next block after release encodes correctly.
- Simultaneous last output transfer and valid_in: the input is not accepted that cycle, since ready_out is still 0.

Optional Feature:
- Macro FEC_PUNCTURE_EN.
- Defined: rate_sel is honoured. Puncture patterns:
  - 2/3: X=10, Y=11; emits X1 Y1 Y2.
  - 3/4: X=101, Y=110; emits X1 Y1 Y2 X3.
  - The pattern phase restarts at data bit 0 of every block.
- Not defined: rate_sel is ignored and the output is always rate 1/2. The puncture phase logic is absent.

Test Plan:
- Rate 1/2, BLOCK_LEN=96, input 96'h558AC4A53A1724E163AC2BF9 (MSB first), ready_in=1 → 192 bits equal 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA (MSB first). first_out on bit 0, last_out on bit 191.
- Same vector sent 5 times back-to-back → identical 192-bit output each block. ready_out returns 1 exactly one cycle after each last_out transfer.
- Backpressure: ready_in low for 10 cycles at output bit 50, then toggled every cycle → fec_out stable while stalled. The sequence matches the first scenario bit-exactly.
- Reset pulse after 50 output bits → valid_out=0 and ready_out=1 immediately. A fresh block then gives the correct 192 bits.
- All-zero block → 192 zeros. All-ones block → 192 ones.
- FEC_PUNCTURE_EN defined, rate_sel=10 with the first scenario's vector → 128 bits equal to the 192-bit stream punctured X1Y1Y2X3. With rate_sel=01 → 144 bits punctured X1Y1Y2.
